rx_path_gearbox: RTL and testbench
==================================

# rx_path_gearbox

Parametrised 1→N / N→1 path gearbox for the RX baseband chain. It replaces divided-clock path splitting with a single-clock, valid-qualified design. It groups a serial sample stream into NUMBER_OF_PATH-wide parallel words for the polyphase mixer/FIR stage. It then re-serialises the multi-channel filter results, with rounding, scaling and optional saturation, back to full-rate per-channel samples. Input realignment is by sync pulse, and buffer overflow and underflow are flagged sticky.

## Interface
- DATA_WIDTH, 16, serial sample width in and out (two's complement)
- ACC_WIDTH, 32, width of each returned filter result
- NUMBER_OF_PATH, 4, polyphase paths per parallel word (≥2)
- NUMBER_OF_CHANNEL, 4, independent output channels
- OUT_SHIFT, 15, arithmetic right shift applied to results (≥1, < ACC_WIDTH)

Ports:
- clock  in  1  single processing clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sync_in  in  1  restart path phase and clear sticky flags
- s_data  in  DATA_WIDTH  serial input sample
- s_valid  in  1  s_data qualifier
- par_data_out  out  DATA_WIDTH*NUMBER_OF_PATH  parallel word; slot 0 (oldest) in LSBs
- par_valid_out  out  1  one-cycle strobe per completed word
- par_data_in  in  ACC_WIDTH*NUMBER_OF_PATH*NUMBER_OF_CHANNEL  results; index (ch*NUMBER_OF_PATH+path)*ACC_WIDTH
- par_valid_in  in  1  par_data_in qualifier
- m_data  out  DATA_WIDTH*NUMBER_OF_CHANNEL  serial output, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- m_valid  out  1  m_data qualifier
- overflow  out  1  sticky: return word dropped
- underflow  out  1  sticky: output stream gap after start
- sat_flag  out  1  any channel saturated on this m_valid

## Operation
- Deserialiser: slot counter 0..NUMBER_OF_PATH-1.
  - Each s_valid writes s_data into the current slot, then advances the counter. It wraps after N-1.
  - Writing slot N-1 loads par_data_out with the full word and pulses par_valid_out.
  - s_valid low leaves the counter and slots untouched.
- sync_in: forces the slot counter to 0 and discards the partial word. It clears overflow and underflow, drops any pending return word and resets the started state.
  - If s_valid is high in the same cycle, that sample lands in slot 0.
- Serialiser buffer: an "active" word plus one "pending" word, and a path index 0..N-1.
  - par_valid_in with active empty → capture into active.
  - par_valid_in with active busy and pending empty → capture into pending.
  - par_valid_in with both full → word dropped, overflow set.
- Emission: while active is valid, emit one sample per cycle, path 0 first, all channels in parallel.
  - After path N-1, promote pending to active in the same cycle. Output stays gapless.
  - A capture in the same cycle as the last emission goes straight into active.
- started is set on the first captured word. When started, active is empty and nothing is captured, underflow is set.
- Scaling per channel: r = (x + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed at ACC_WIDTH+1 bits, so the rounding add cannot wrap.
  - The result is then reduced to DATA_WIDTH (see Configuration).

## Timing
- Reset: all outputs 0; slot counter 0, path index 0; active/pending empty; started 0.
- par_valid_out is high the cycle after the clock edge that accepted the slot-N-1 sample. par_data_out holds until the next word.
- Serialiser latency: par_valid_in at edge t (buffer empty) gives first m_valid at edge t+2, then N consecutive cycles.
  - Stage 1 is capture/select; stage 2 is the round/saturate register.
- par_valid_in every N cycles produces continuous m_valid with no gaps and no flags.
- Reset mid-word: everything returns to reset state immediately; partial words are lost.
- sync_in and par_valid_in in the same cycle: the buffer is flushed first, then the new word is captured into active.

## Configuration
- RX_GEARBOX_SAT_EN defined: r is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. sat_flag is high with m_valid when any channel clamps.
- Undefined: r is truncated to its low DATA_WIDTH bits (wrap). sat_flag is tied 0.

## Test plan
- DATA_WIDTH=16, N=4: feed s_data 1,2,3,4 with s_valid continuous → par_data_out = 0x0004_0003_0002_0001, one-cycle par_valid_out strobe on the cycle after sample 4.
- Feed 1,2 then assert sync_in together with sample 9, then 10,11,12 → word = {12,11,10,9}; samples 1,2 never appear.
- OUT_SHIFT=15, ch0 paths = 0x0000_8000, 0x0000_4000, 0xFFFF_8000, 0x0000_C000 → m_data ch0 = 1, 1 (0.5 rounds up), -1, 2 on four consecutive cycles starting at t+2.
- Macro defined: ch0 input 0x4000_0000 → m_data ch0 = 0x7FFF, sat_flag=1. Macro undefined: same input → 0x8000, sat_flag=0.
- Three par_valid_in on consecutive cycles → first two words emitted back-to-back (8 samples); third dropped; overflow=1 until sync_in.
- Words spaced 4 cycles → continuous m_valid. Then one word spaced 6 cycles → underflow=1; a later sync_in clears it.

Source files
------------

// File: rtl/rx_path_gearbox.sv
// Single-clock 1->N deserialiser and N->1 round/scale serialiser for the RX polyphase stage.
// Build option: define RX_GEARBOX_SAT_EN to clamp scaled results (else they wrap).

module rx_gb_scale #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_SHIFT  = 15
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  sat
);
  localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] rnd, shr;

  // One guard bit so the rounding add never wraps.
  assign rnd = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
  assign shr = rnd >>> OUT_SHIFT;

`ifdef RX_GEARBOX_SAT_EN
  always_comb begin
    sat = 1'b0;
    res = shr[DATA_WIDTH-1:0];
    if (shr > MAXV) begin
      sat = 1'b1;
      res = MAXV[DATA_WIDTH-1:0];
    end else if (shr < MINV) begin
      sat = 1'b1;
      res = MINV[DATA_WIDTH-1:0];
    end
  end
`else
  assign res = shr[DATA_WIDTH-1:0];
  assign sat = 1'b0;
`endif
endmodule

module rx_path_gearbox #(
  parameter int DATA_WIDTH        = 16,
  parameter int ACC_WIDTH         = 32,
  parameter int NUMBER_OF_PATH    = 4,
  parameter int NUMBER_OF_CHANNEL = 4,
  parameter int OUT_SHIFT         = 15
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            sync_in,
  input  logic [DATA_WIDTH-1:0]                           s_data,
  input  logic                                            s_valid,
  output logic [DATA_WIDTH*NUMBER_OF_PATH-1:0]            par_data_out,
  output logic                                            par_valid_out,
  input  logic [ACC_WIDTH*NUMBER_OF_PATH*NUMBER_OF_CHANNEL-1:0] par_data_in,
  input  logic                                            par_valid_in,
  output logic [DATA_WIDTH*NUMBER_OF_CHANNEL-1:0]         m_data,
  output logic                                            m_valid,
  output logic                                            overflow,
  output logic                                            underflow,
  output logic                                            sat_flag
);
  localparam int IW     = $clog2(NUMBER_OF_PATH);
  localparam int SW     = ACC_WIDTH*NUMBER_OF_PATH*NUMBER_OF_CHANNEL;
  localparam int STAGES = 1;
  localparam logic [IW-1:0] LAST = IW'(NUMBER_OF_PATH - 1);

  // ---------------- deserialiser ----------------
  logic [IW-1:0] slot, wr_slot;
  logic [NUMBER_OF_PATH-1:0][DATA_WIDTH-1:0] slots, word_nxt;

  assign wr_slot = sync_in ? '0 : slot;

  always_comb begin
    word_nxt = slots;
    word_nxt[NUMBER_OF_PATH-1] = s_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot          <= '0;
      slots         <= '0;
      par_data_out  <= '0;
      par_valid_out <= 1'b0;
    end else begin
      par_valid_out <= 1'b0;
      if (s_valid) begin
        slots[wr_slot] <= s_data;
        if (wr_slot == LAST) begin
          slot          <= '0;
          par_data_out  <= word_nxt;
          par_valid_out <= 1'b1;
        end else begin
          slot <= wr_slot + 1'b1;
        end
      end else if (sync_in) begin
        slot <= '0;
      end
    end
  end

  // ---------------- serialiser ----------------
  logic [SW-1:0] act_q, pend_q;
  logic          act_vld, pend_vld, started, last;
  logic [IW-1:0] idx;
  logic [NUMBER_OF_CHANNEL-1:0][ACC_WIDTH-1:0]  sel_d, sel_q;
  logic [NUMBER_OF_CHANNEL-1:0][DATA_WIDTH-1:0] res_d;
  logic [NUMBER_OF_CHANNEL-1:0]                 sat_d;
  logic [STAGES:0] vld_pipe;

  assign last = act_vld && (idx == LAST);

  always_comb begin
    sel_d = '0;
    for (int c = 0; c < NUMBER_OF_CHANNEL; c++)
      sel_d[c] = act_q[(c*NUMBER_OF_PATH + int'(idx))*ACC_WIDTH +: ACC_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q     <= '0;
      pend_q    <= '0;
      act_vld   <= 1'b0;
      pend_vld  <= 1'b0;
      started   <= 1'b0;
      idx       <= '0;
      sel_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (act_vld) begin
        sel_q <= sel_d;
        idx   <= last ? '0 : idx + 1'b1;
      end
      if (sync_in) begin
        // Flush first, then the coincident word (if any) restarts the stream.
        act_vld   <= par_valid_in;
        pend_vld  <= 1'b0;
        idx       <= '0;
        started   <= par_valid_in;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        if (par_valid_in) act_q <= par_data_in;
      end else begin
        if (par_valid_in) started <= 1'b1;
        if (started && !act_vld && !par_valid_in) underflow <= 1'b1;
        if (!act_vld) begin
          if (par_valid_in) begin
            act_q   <= par_data_in;
            act_vld <= 1'b1;
          end
        end else if (last) begin
          if (pend_vld) begin
            act_q    <= pend_q;
            pend_vld <= par_valid_in;
            if (par_valid_in) pend_q <= par_data_in;
          end else if (par_valid_in) begin
            act_q <= par_data_in;
          end else begin
            act_vld <= 1'b0;
          end
        end else if (par_valid_in) begin
          if (!pend_vld) begin
            pend_q   <= par_data_in;
            pend_vld <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NUMBER_OF_CHANNEL; c++) begin : g_lane
    rx_gb_scale #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_SHIFT  (OUT_SHIFT)
    ) u_lane (
      .acc (sel_q[c]),
      .res (res_d[c]),
      .sat (sat_d[c])
    );
  end

  // vld_pipe[0]: select register holds a sample; vld_pipe[STAGES]: output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      m_data   <= '0;
      sat_flag <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], act_vld};
      sat_flag <= 1'b0;
      if (vld_pipe[STAGES-1]) begin
        m_data   <= res_d;
        sat_flag <= |sat_d;
      end
    end
  end

  assign m_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_rx_path_gearbox.sv
// Directed bench for rx_path_gearbox: deserialiser checks plus a scoreboard on the serial output.
module tb_rx_path_gearbox;
  localparam int DW = 16, AW = 32, N = 4, NC = 4, SH = 15;
  localparam int WW = AW*N*NC;

  logic clock = 1'b0, reset = 1'b1, sync_in = 1'b0, s_valid = 1'b0, par_valid_in = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic [WW-1:0]    par_data_in = '0;
  logic [DW*N-1:0]  par_data_out;
  logic [DW*NC-1:0] m_data;
  logic par_valid_out, m_valid, overflow, underflow, sat_flag;

  rx_path_gearbox dut (
    .clock(clock), .reset(reset), .sync_in(sync_in), .s_data(s_data), .s_valid(s_valid),
    .par_data_out(par_data_out), .par_valid_out(par_valid_out),
    .par_data_in(par_data_in), .par_valid_in(par_valid_in),
    .m_data(m_data), .m_valid(m_valid), .overflow(overflow), .underflow(underflow),
    .sat_flag(sat_flag)
  );

  always #5 clock = ~clock;

  typedef struct { logic [DW*NC-1:0] data; logic sat; } exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0, outs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [AW-1:0] acc, output logic sat);
    longint x, r;
    x = longint'($signed(acc));
    r = (x + (longint'(1) <<< (SH-1))) >>> SH;
    sat = 1'b0;
`ifdef RX_GEARBOX_SAT_EN
    if (r > 32767)       begin r = 32767;  sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
`endif
    return r[DW-1:0];
  endfunction

  task automatic push_word(input logic [WW-1:0] w);
    exp_t e;
    logic s;
    for (int p = 0; p < N; p++) begin
      e.sat = 1'b0;
      for (int c = 0; c < NC; c++) begin
        e.data[c*DW +: DW] = model(w[(c*N+p)*AW +: AW], s);
        e.sat |= s;
      end
      sbq.push_back(e);
    end
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int k = 0; k < N*NC; k++) w[k*AW +: AW] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit expect_kept);
    par_data_in = w; par_valid_in = 1'b1;
    if (expect_kept) push_word(w);
  endtask

  // Output monitor pops the scoreboard on every m_valid.
  always @(negedge clock) begin
    if (!reset && m_valid) begin
      outs++;
      if (sbq.size() == 0) begin
        chk("unexpected_m_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("m_data", m_data, e.data);
        chk("sat_flag", sat_flag, e.sat);
      end
    end
  end

  initial begin
    logic [WW-1:0] w;
    logic [DW-1:0] v;
    // reset state
    repeat (2) tick();
    chk("rst_par_valid_out", par_valid_out, 0);
    chk("rst_par_data_out", par_data_out, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_flags", {overflow, underflow, sat_flag}, 0);
    reset = 1'b0;
    tick();

    // 1..4 -> one word, strobe after sample 4
    s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = DW'(i);
      tick();
      if (i == 3) chk("pv_before_last", par_valid_out, 0);
    end
    chk("pv_strobe", par_valid_out, 1);
    chk("word_1234", par_data_out, 64'h0004_0003_0002_0001);
    s_valid = 1'b0;
    tick();
    chk("pv_one_cycle", par_valid_out, 0);
    chk("word_hold", par_data_out, 64'h0004_0003_0002_0001);

    // sync realign: 1,2 discarded, 9 lands in slot 0
    s_valid = 1'b1;
    s_data = 16'd1; tick();
    s_data = 16'd2; tick();
    sync_in = 1'b1; s_data = 16'd9; tick();
    sync_in = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      s_data = DW'(i);
      tick();
    end
    chk("sync_pv", par_valid_out, 1);
    chk("word_sync", par_data_out, 64'h000C_000B_000A_0009);
    s_valid = 1'b0;
    tick();

    // rounding word on ch0, latency t+2
    w = rand_word();
    w[0*AW +: AW] = 32'h0000_8000;
    w[1*AW +: AW] = 32'h0000_4000;
    w[2*AW +: AW] = 32'hFFFF_8000;
    w[3*AW +: AW] = 32'h0000_C000;
    send_word(w, 1);
    tick();
    par_valid_in = 1'b0;
    tick();
    chk("lat_t1", m_valid, 0);
    tick();
    chk("lat_t2", m_valid, 1);
    chk("round_p0", m_data[DW-1:0], 16'd1);
    tick(); chk("round_p1", m_data[DW-1:0], 16'd1);
    tick(); chk("round_p2", m_data[DW-1:0], 16'hFFFF);
    tick(); chk("round_p3", m_data[DW-1:0], 16'd2);
    repeat (3) tick();
    chk("underflow_idle", underflow, 1);
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    chk("sync_clears_uf", underflow, 0);

    // saturation / wrap on ch0
    w = rand_word();
    w[0*AW +: AW] = 32'h4000_0000;
    send_word(w, 1);
    tick();
    par_valid_in = 1'b0;
    tick(); tick();
`ifdef RX_GEARBOX_SAT_EN
    chk("sat_value", m_data[DW-1:0], 16'h7FFF);
    chk("sat_flag_on", sat_flag, 1);
`else
    chk("wrap_value", m_data[DW-1:0], 16'h8000);
    v = m_data[DW-1:0];
    chk("wrap_sat_off", sat_flag, 0);
`endif
    repeat (6) tick();
    sync_in = 1'b1; tick(); sync_in = 1'b0;

    // three back-to-back words: third dropped
    chk("ovf_clear", overflow, 0);
    send_word(rand_word(), 1); tick();
    send_word(rand_word(), 1); tick();
    send_word(rand_word(), 0); tick();
    par_valid_in = 1'b0;
    chk("ovf_set", overflow, 1);
    repeat (10) tick();
    chk("ovf_sticky", overflow, 1);
    chk("drained_ovf", sbq.size(), 0);
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    chk("ovf_sync_clear", overflow, 0);

    // words every 4 cycles gapless, then a 6-cycle gap
    for (int i = 0; i < 24; i++) begin
      if ((i % 4 == 0 && i <= 12) || i == 18) send_word(rand_word(), 1);
      else par_valid_in = 1'b0;
      tick();
      if (i >= 2 && i <= 17) chk("gapless_m_valid", m_valid, 1);
      if (i == 16) chk("no_underflow", underflow, 0);
      if (i == 17) chk("underflow_gap", underflow, 1);
    end
    par_valid_in = 1'b0;
    repeat (4) tick();
    chk("drained_gap", sbq.size(), 0);
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    chk("uf_sync_clear", underflow, 0);

    // reset mid-word
    s_valid = 1'b1;
    s_data = 16'hAAAA; tick();
    s_data = 16'hBBBB; tick();
    reset = 1'b1; #2;
    chk("async_rst_word", par_data_out, 0);
    chk("async_rst_m", {m_valid, m_data}, 0);
    tick();
    reset = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("word_after_rst", par_data_out, 64'h0008_0007_0006_0005);
    tick();

    chk("outputs_seen", outs, 4 + 4 + 8 + 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
